// File: rtl/svc_dmem_arb2.sv
// Two-port round-robin arbiter with a bounded hold window in front of one single-port, 1-cycle-latency DMEM.
// Define SVC_DMEM_ARB2_STATS_EN to add grant/conflict/wait statistics counters.
module svc_dmem_arb2 #(
  parameter int AW       = 12,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic            a_wen,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW-1:0]   a_wdata,
  input  logic [DW/8-1:0] a_wstrb,
  output logic            a_rvalid,
  output logic [DW-1:0]   a_rdata,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic            b_wen,
  input  logic [AW-1:0]   b_addr,
  input  logic [DW-1:0]   b_wdata,
  input  logic [DW/8-1:0] b_wstrb,
  output logic            b_rvalid,
  output logic [DW-1:0]   b_rdata,
  output logic            mem_en,
  output logic            mem_wen,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic [DW-1:0]   mem_rdata
`ifdef SVC_DMEM_ARB2_STATS_EN
  ,
  input  logic            stat_clr,
  output logic [31:0]     stat_a_grants,
  output logic [31:0]     stat_b_grants,
  output logic [31:0]     stat_conflicts,
  output logic [15:0]     stat_max_wait
`endif
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  owner_t     owner_q, owner_d;
  logic       last_b_q, last_b_d;
  logic [7:0] hold_q, hold_d;
  logic       rd_pending_q, rd_port_q;
  logic       grant_a, grant_b;

  // Grants are gated by rst_n so that every output reads 0 while reset is held.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst_n) begin
      if (a_valid && !b_valid) begin
        grant_a = 1'b1;
      end else if (b_valid && !a_valid) begin
        grant_b = 1'b1;
      end else if (a_valid && b_valid) begin
        if (owner_q == OWN_A && hold_q < HOLD_LIM) begin
          grant_a = 1'b1;
        end else if (owner_q == OWN_B && hold_q < HOLD_LIM) begin
          grant_b = 1'b1;
        end else if (last_b_q) begin
          grant_a = 1'b1;
        end else begin
          grant_b = 1'b1;
        end
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_comb begin
    owner_d  = owner_q;
    last_b_d = last_b_q;
    hold_d   = hold_q;
    if (grant_a || grant_b) begin
      owner_d  = grant_a ? OWN_A : OWN_B;
      last_b_d = grant_b;
      if (owner_q == owner_d) begin
        hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
      end else begin
        hold_d = 8'd0;
      end
    end else begin
      owner_d = OWN_IDLE;
      hold_d  = 8'd0;
    end
  end

  // last resets to B so that port A wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= OWN_IDLE;
      last_b_q <= 1'b1;
      hold_q   <= 8'd0;
    end else begin
      owner_q  <= owner_d;
      last_b_q <= last_b_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    mem_en    = grant_a || grant_b;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (grant_a) begin
      mem_wen   = a_wen;
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
      mem_wstrb = a_wstrb;
    end else if (grant_b) begin
      mem_wen   = b_wen;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
      mem_wstrb = b_wstrb;
    end
  end

  // Tag of the read issued last cycle; reset drops any response still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending_q <= 1'b0;
      rd_port_q    <= 1'b0;
    end else begin
      rd_pending_q <= mem_en && !mem_wen;
      rd_port_q    <= grant_b;
    end
  end

  assign a_rvalid = rd_pending_q && !rd_port_q;
  assign b_rvalid = rd_pending_q && rd_port_q;
  assign a_rdata  = a_rvalid ? mem_rdata : '0;
  assign b_rdata  = b_rvalid ? mem_rdata : '0;

`ifdef SVC_DMEM_ARB2_STATS_EN
  logic [15:0] wait_a_q, wait_b_q;
  logic [15:0] wait_a_d, wait_b_d, max_wait_d;

  // Per-port runs of valid-but-not-granted cycles feed the longest-wait statistic.
  always_comb begin
    wait_a_d = 16'd0;
    wait_b_d = 16'd0;
    if (a_valid && !grant_a) begin
      wait_a_d = (wait_a_q == 16'hFFFF) ? wait_a_q : wait_a_q + 16'd1;
    end
    if (b_valid && !grant_b) begin
      wait_b_d = (wait_b_q == 16'hFFFF) ? wait_b_q : wait_b_q + 16'd1;
    end
    max_wait_d = stat_max_wait;
    if (wait_a_d > max_wait_d) begin
      max_wait_d = wait_a_d;
    end
    if (wait_b_d > max_wait_d) begin
      max_wait_d = wait_b_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_a_grants  <= 32'd0;
      stat_b_grants  <= 32'd0;
      stat_conflicts <= 32'd0;
      stat_max_wait  <= 16'd0;
      wait_a_q       <= 16'd0;
      wait_b_q       <= 16'd0;
    end else if (stat_clr) begin
      stat_a_grants  <= 32'd0;
      stat_b_grants  <= 32'd0;
      stat_conflicts <= 32'd0;
      stat_max_wait  <= 16'd0;
      wait_a_q       <= 16'd0;
      wait_b_q       <= 16'd0;
    end else begin
      if (grant_a && stat_a_grants != 32'hFFFF_FFFF) begin
        stat_a_grants <= stat_a_grants + 32'd1;
      end
      if (grant_b && stat_b_grants != 32'hFFFF_FFFF) begin
        stat_b_grants <= stat_b_grants + 32'd1;
      end
      if (a_valid && b_valid && stat_conflicts != 32'hFFFF_FFFF) begin
        stat_conflicts <= stat_conflicts + 32'd1;
      end
      stat_max_wait <= max_wait_d;
      wait_a_q      <= wait_a_d;
      wait_b_q      <= wait_b_d;
    end
  end
`endif

endmodule
